jtag_tap_sync: RTL and testbench



---
 rtl/jtag_tap_sync.sv | 169 ++++++++++++++++
 tb/tb_jtag_tap_sync.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_sync.sv
// JTAG TAP controller oversampled in the core clock domain.
// Holds the IR, IDCODE, BYPASS and DMI registers and strobes the debug module.
module jtag_tap_sync #(
    parameter int                  IR_WIDTH  = 5,
    parameter logic [31:0]         IDCODE    = 32'h1BEEF001,
    parameter int                  DMI_WIDTH = 41,
    parameter logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'('h01),
    parameter logic [IR_WIDTH-1:0] IR_DMI    = IR_WIDTH'('h11)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tck,
    input  logic                 tms,
    input  logic                 tdi,
    input  logic                 trst,
    output logic                 tdo,
    output logic [3:0]           tap_state,
    output logic [IR_WIDTH-1:0]  ir,
    output logic                 dmi_capture,
    input  logic [DMI_WIDTH-1:0] dmi_rdata,
    output logic                 dmi_update,
    output logic [DMI_WIDTH-1:0] dmi_wdata
);

    localparam int DR_W = (DMI_WIDTH > 32) ? DMI_WIDTH : 32;

    typedef enum logic [3:0] {
        TLR      = 4'd0,
        RTI      = 4'd1,
        SEL_DR   = 4'd2,
        CAP_DR   = 4'd3,
        SH_DR    = 4'd4,
        EX1_DR   = 4'd5,
        PAUSE_DR = 4'd6,
        EX2_DR   = 4'd7,
        UPD_DR   = 4'd8,
        SEL_IR   = 4'd9,
        CAP_IR   = 4'd10,
        SH_IR    = 4'd11,
        EX1_IR   = 4'd12,
        PAUSE_IR = 4'd13,
        EX2_IR   = 4'd14,
        UPD_IR   = 4'd15
    } state_t;

    state_t state, state_nx;

    logic tck_m, tck_s, tck_q;
    logic tms_m, tms_s;
    logic tdi_m, tdi_s;
    logic trst_m, trst_s;
    logic tck_rise, tck_fall, tap_rst;

    logic [IR_WIDTH-1:0] ir_sr;
    logic [DR_W-1:0]     dr_sr, dr_cap, dr_sh;
    logic                byp, sel_idc, sel_dmi, sel_dr, tdo_nx;

    // Two-flop synchronisers; pins are quasi-static relative to clk.
    always_ff @(posedge clk) begin
        tck_m  <= tck;
        tck_s  <= tck_m;
        tck_q  <= tck_s;
        tms_m  <= tms;
        tms_s  <= tms_m;
        tdi_m  <= tdi;
        tdi_s  <= tdi_m;
        trst_m <= trst;
        trst_s <= trst_m;
    end

    assign tck_rise  = tck_s & ~tck_q;
    assign tck_fall  = ~tck_s & tck_q;
    assign tap_rst   = rst | trst_s;
    assign tap_state = state;

    always_ff @(posedge clk) begin
        if (tap_rst)
            state <= TLR;
        else if (tck_rise)
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            TLR:      state_nx = tms_s ? TLR    : RTI;
            RTI:      state_nx = tms_s ? SEL_DR : RTI;
            SEL_DR:   state_nx = tms_s ? SEL_IR : CAP_DR;
            CAP_DR:   state_nx = tms_s ? EX1_DR : SH_DR;
            SH_DR:    state_nx = tms_s ? EX1_DR : SH_DR;
            EX1_DR:   state_nx = tms_s ? UPD_DR : PAUSE_DR;
            PAUSE_DR: state_nx = tms_s ? EX2_DR : PAUSE_DR;
            EX2_DR:   state_nx = tms_s ? UPD_DR : SH_DR;
            UPD_DR:   state_nx = tms_s ? SEL_DR : RTI;
            SEL_IR:   state_nx = tms_s ? TLR    : CAP_IR;
            CAP_IR:   state_nx = tms_s ? EX1_IR : SH_IR;
            SH_IR:    state_nx = tms_s ? EX1_IR : SH_IR;
            EX1_IR:   state_nx = tms_s ? UPD_IR : PAUSE_IR;
            PAUSE_IR: state_nx = tms_s ? EX2_IR : PAUSE_IR;
            EX2_IR:   state_nx = tms_s ? UPD_IR : SH_IR;
            UPD_IR:   state_nx = tms_s ? SEL_DR : RTI;
        endcase
    end

    assign sel_idc = (ir == IR_IDCODE);
    assign sel_dmi = (ir == IR_DMI);
    assign sel_dr  = sel_idc | sel_dmi;

    // Shared shift register; tdi enters at the MSB of whichever view is active.
    always_comb begin
        dr_cap = dr_sr;
        dr_sh  = dr_sr >> 1;
        if (sel_dmi) begin
            dr_cap[DMI_WIDTH-1:0] = dmi_rdata;
            dr_sh[DMI_WIDTH-1]    = tdi_s;
        end else begin
            dr_cap[31:0] = IDCODE;
            dr_sh[31]    = tdi_s;
        end
    end

    always_comb begin
        tdo_nx = 1'b0;
        if (state == SH_IR)
            tdo_nx = ir_sr[0];
        else if (state == SH_DR)
            tdo_nx = sel_dr ? dr_sr[0] : byp;
    end

    always_ff @(posedge clk) begin
        if (tap_rst) begin
            ir          <= IR_IDCODE;
            ir_sr       <= '0;
            dr_sr       <= '0;
            byp         <= 1'b0;
            tdo         <= 1'b0;
            dmi_capture <= 1'b0;
            dmi_update  <= 1'b0;
            dmi_wdata   <= '0;
        end else begin
            dmi_capture <= tck_rise && state == SEL_DR && !tms_s && sel_dmi;
            dmi_update  <= tck_rise && state == UPD_DR && sel_dmi;
            if (tck_fall)
                tdo <= tdo_nx;
            if (tck_rise) begin
                case (state)
                    CAP_IR: ir_sr <= IR_WIDTH'(2'b01);
                    SH_IR:  ir_sr <= {tdi_s, ir_sr[IR_WIDTH-1:1]};
                    UPD_IR: ir    <= ir_sr;
                    CAP_DR: begin
                        if (sel_dr) dr_sr <= dr_cap;
                        else        byp   <= 1'b0;
                    end
                    SH_DR: begin
                        if (sel_dr) dr_sr <= dr_sh;
                        else        byp   <= tdi_s;
                    end
                    UPD_DR: begin
                        if (sel_dmi) dmi_wdata <= dr_sr[DMI_WIDTH-1:0];
                    end
                    default: ;
                endcase
            end
            if (state == TLR)
                ir <= IR_IDCODE;
        end
    end

endmodule

// File: tb/tb_jtag_tap_sync.sv
// Scoreboard bench for jtag_tap_sync: stimulus queues expectations,
// monitors compare after every tck fall and on every dmi_update pulse.
module tb_jtag_tap_sync;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tck = 1'b0;
    logic        tms = 1'b1;
    logic        tdi = 1'b0;
    logic        trst = 1'b0;
    logic        tdo;
    logic [3:0]  tap_state;
    logic [4:0]  ir;
    logic        dmi_capture;
    logic        dmi_update;
    logic [40:0] dmi_rdata = '0;
    logic [40:0] dmi_wdata;

    always #5 clk = ~clk;

    jtag_tap_sync dut (
        .clk(clk),
        .rst(rst),
        .tck(tck),
        .tms(tms),
        .tdi(tdi),
        .trst(trst),
        .tdo(tdo),
        .tap_state(tap_state),
        .ir(ir),
        .dmi_capture(dmi_capture),
        .dmi_rdata(dmi_rdata),
        .dmi_update(dmi_update),
        .dmi_wdata(dmi_wdata)
    );

    typedef struct {
        int         st;
        bit         ct;
        logic       t;
        bit         ci;
        logic [4:0] ei;
    } exp_t;

    exp_t        exp_q[$];
    logic [40:0] dmi_q[$];

    int npass = 0;
    int ntot = 0;
    int upd_cyc = 0;
    int cap_cyc = 0;
    int hp = 4;
    int mst = 0;
    int nfall = 0;

    // 1149.1 transition table: next state for tms=0 / tms=1
    int nx0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int nx1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

    logic [31:0] idv = 32'h1BEEF001;
    logic [40:0] rdv = 41'h1_2345_6789;
    logic [40:0] wdv = 41'h0AA_5555_AAAA;
    logic [3:0]  pat = 4'b1101;
    logic [4:0]  irv = 5'h11;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        ntot++;
        if (act === exp)
            npass++;
        else
            $display("FAIL %s (fall %0d, t=%0t): got %0h expected %0h",
                     nm, nfall, $time, act, exp);
    endfunction

    task automatic tbit(input logic m, input logic d,
                        input bit ct = 0, input logic t = 1'b0,
                        input bit ci = 0, input logic [4:0] ei = 5'h0);
        exp_t e;
        mst = m ? nx1[mst] : nx0[mst];
        e.st = mst;
        e.ct = ct;
        e.t  = t;
        e.ci = ci;
        e.ei = ei;
        exp_q.push_back(e);
        tms = m;
        tdi = d;
        repeat (hp) @(negedge clk);
        tck = 1'b1;
        repeat (hp) @(negedge clk);
        tck = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            ntot++;
            $display("FAIL drain: %0d expectations never consumed", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor: after each tck fall the new tdo/state are settled 3 clk later.
    initial begin : tck_mon
        exp_t e;
        forever begin
            @(negedge tck);
            repeat (4) @(negedge clk);
            nfall++;
            if (exp_q.size() == 0) begin
                ntot++;
                $display("FAIL tck_fall: no expectation queued, state %0d", tap_state);
            end else begin
                e = exp_q.pop_front();
                chk("state", tap_state, e.st);
                if (e.ct) chk("tdo", tdo, e.t);
                if (e.ci) chk("ir", ir, e.ei);
            end
        end
    end

    always @(negedge clk) begin
        if (dmi_capture) cap_cyc++;
        if (dmi_update) begin
            upd_cyc++;
            if (dmi_q.size() == 0) begin
                ntot++;
                $display("FAIL dmi_update: unexpected pulse, wdata %0h", dmi_wdata);
            end else begin
                chk("dmi_update_wdata", dmi_wdata, dmi_q.pop_front());
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_state", tap_state, 0);
        chk("rst_ir", ir, 5'h01);
        chk("rst_tdo", tdo, 0);
        chk("rst_dmi_update", dmi_update, 0);
        chk("rst_dmi_capture", dmi_capture, 0);
        chk("rst_dmi_wdata", dmi_wdata, 0);

        // Walk into Shift-DR, then five tms=1 back to Test-Logic-Reset
        tbit(0, 0); tbit(1, 0); tbit(0, 0); tbit(0, 0);
        for (int i = 0; i < 5; i++) tbit(1, 0, 0, 0, i == 4, 5'h01);

        // IDCODE readout, LSB first
        tbit(0, 0); tbit(1, 0); tbit(0, 0);
        tbit(0, 0, 1, idv[0]);
        for (int i = 1; i < 32; i++) tbit(0, 0, 1, idv[i]);
        tbit(1, 0, 1, 0);

        // IR capture pattern, load BYPASS
        tbit(1, 0); tbit(1, 0); tbit(1, 0); tbit(0, 0);
        tbit(0, 1, 1, 1);
        for (int i = 0; i < 4; i++) tbit(0, 1, 1, 0);
        tbit(1, 1, 1, 0);
        tbit(1, 0);
        tbit(0, 0, 0, 0, 1, 5'h1F);

        // BYPASS: one-bit delay, captured 0 first
        tbit(1, 0); tbit(0, 0);
        tbit(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) tbit(0, pat[i], 1, pat[i]);
        tbit(1, 0, 1, 0);

        // Load DMI opcode
        tbit(1, 0); tbit(1, 0); tbit(1, 0); tbit(0, 0);
        tbit(0, 0, 1, 1);
        for (int i = 0; i < 4; i++) tbit(0, irv[i]);
        tbit(1, irv[4]);
        tbit(1, 0);
        tbit(0, 0, 0, 0, 1, 5'h11);

        // DMI capture / shift / update
        dmi_rdata = rdv;
        dmi_q.push_back(wdv);
        tbit(1, 0); tbit(0, 0);
        tbit(0, 0, 1, rdv[0]);
        for (int i = 0; i < 40; i++) tbit(0, wdv[i], 1, rdv[i+1]);
        tbit(1, wdv[40], 1, 0);
        tbit(1, 0);
        tbit(0, 0);
        drain();
        chk("dmi_wdata_hold", dmi_wdata, wdv);
        chk("dmi_capture_cycles", cap_cyc, 1);

        // rst mid Shift-DR: partial shift dropped, no update
        tbit(1, 0); tbit(0, 0);
        tbit(0, 0, 1, rdv[0]);
        for (int i = 1; i < 4; i++) tbit(0, 1, 1, rdv[i]);
        drain();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mst = 0;
        chk("midshift_rst_state", tap_state, 0);
        chk("midshift_rst_ir", ir, 5'h01);
        chk("midshift_rst_tdo", tdo, 0);
        chk("midshift_rst_wdata", dmi_wdata, 0);
        repeat (10) @(negedge clk);
        chk("midshift_rst_no_update", upd_cyc, 1);

        // Load BYPASS, re-enter Shift-IR with tdo=1, then trst
        tbit(0, 0); tbit(1, 0); tbit(1, 0); tbit(0, 0);
        tbit(0, 1, 1, 1);
        for (int i = 0; i < 4; i++) tbit(0, 1, 1, 0);
        tbit(1, 1, 1, 0);
        tbit(1, 0);
        tbit(0, 0, 0, 0, 1, 5'h1F);
        tbit(1, 0); tbit(1, 0); tbit(0, 0);
        tbit(0, 1, 1, 1);
        for (int i = 0; i < 4; i++) tbit(0, 1, 1, 0);
        tbit(0, 1, 1, 1);
        drain();
        trst = 1'b1;
        repeat (4) @(negedge clk);
        trst = 1'b0;
        mst = 0;
        repeat (3) @(negedge clk);
        chk("trst_state", tap_state, 0);
        chk("trst_ir", ir, 5'h01);
        chk("trst_tdo", tdo, 0);

        // Minimum legal tck timing with random tms
        hp = 3;
        for (int i = 0; i < 60; i++) tbit(1'($urandom_range(0, 1)), 0);
        for (int i = 0; i < 5; i++) tbit(1, 0, 0, 0, i == 4, 5'h01);
        drain();

        chk("dmi_update_cycles", upd_cyc, 1);
        chk("dmi_capture_cycles_total", cap_cyc, 2);
        chk("dmi_q_empty", dmi_q.size(), 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
